// File: rtl/morse_pkg.sv
// Shared types and constants for the Morse receiver: FSM states, symbol values
// and the A..Z letter codes produced by the decoder.
package morse_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PRESS = 2'd1,
        S_GAP   = 2'd2,
        S_EMIT  = 2'd3
    } state_t;

    localparam logic SYM_DOT  = 1'b0;
    localparam logic SYM_DASH = 1'b1;

    localparam logic [2:0] MAX_SYM = 3'd4;

    localparam logic [4:0] L_A = 5'd0,  L_B = 5'd1,  L_C = 5'd2,  L_D = 5'd3;
    localparam logic [4:0] L_E = 5'd4,  L_F = 5'd5,  L_G = 5'd6,  L_H = 5'd7;
    localparam logic [4:0] L_I = 5'd8,  L_J = 5'd9,  L_K = 5'd10, L_L = 5'd11;
    localparam logic [4:0] L_M = 5'd12, L_N = 5'd13, L_O = 5'd14, L_P = 5'd15;
    localparam logic [4:0] L_Q = 5'd16, L_R = 5'd17, L_S = 5'd18, L_T = 5'd19;
    localparam logic [4:0] L_U = 5'd20, L_V = 5'd21, L_W = 5'd22, L_X = 5'd23;
    localparam logic [4:0] L_Y = 5'd24, L_Z = 5'd25;

endpackage

// File: rtl/morse_decoder_if.sv
// Key-side inputs and letter-side outputs of the Morse decoder.
// The master drives key/tick; the slave (decoder) drives the results.
interface morse_decoder_if;
    logic       tick;
    logic       key;
    logic [4:0] letter;
    logic       letter_valid;
    logic       error;
    logic       busy;

    modport master (output tick, key, input letter, letter_valid, error, busy);
    modport slave  (input tick, key, output letter, letter_valid, error, busy);
endinterface

// File: rtl/morse_lut.sv
// International Morse table: (pattern, len) -> {hit, letter code}.
// The first symbol sits in pattern[len-1]; bits above len are masked off.
module morse_lut
    import morse_pkg::*;
(
    input  logic [3:0] pattern,
    input  logic [2:0] len,
    output logic       hit,
    output logic [4:0] code
);

    logic [3:0] mask;
    logic [6:0] sel;

    // For len==4 the shift overflows to 0 and the subtraction wraps to all ones.
    assign mask = (4'd1 << len) - 4'd1;
    assign sel  = {len, pattern & mask};

    always_comb begin
        hit  = 1'b1;
        code = L_A;
        case (sel)
            {3'd1, 4'b0000}: code = L_E;
            {3'd1, 4'b0001}: code = L_T;
            {3'd2, 4'b0000}: code = L_I;
            {3'd2, 4'b0001}: code = L_A;
            {3'd2, 4'b0010}: code = L_N;
            {3'd2, 4'b0011}: code = L_M;
            {3'd3, 4'b0000}: code = L_S;
            {3'd3, 4'b0001}: code = L_U;
            {3'd3, 4'b0010}: code = L_R;
            {3'd3, 4'b0011}: code = L_W;
            {3'd3, 4'b0100}: code = L_D;
            {3'd3, 4'b0101}: code = L_K;
            {3'd3, 4'b0110}: code = L_G;
            {3'd3, 4'b0111}: code = L_O;
            {3'd4, 4'b0000}: code = L_H;
            {3'd4, 4'b0001}: code = L_V;
            {3'd4, 4'b0010}: code = L_F;
            {3'd4, 4'b0100}: code = L_L;
            {3'd4, 4'b0110}: code = L_P;
            {3'd4, 4'b0111}: code = L_J;
            {3'd4, 4'b1000}: code = L_B;
            {3'd4, 4'b1001}: code = L_X;
            {3'd4, 4'b1010}: code = L_C;
            {3'd4, 4'b1011}: code = L_Y;
            {3'd4, 4'b1100}: code = L_Z;
            {3'd4, 4'b1101}: code = L_Q;
            default:         hit  = 1'b0;
        endcase
    end

endmodule

// File: rtl/morse_decoder.sv
// Morse receiver: times key presses and gaps in tick units, builds up to four
// dot/dash symbols and emits one letter code or an error pulse per character.
module morse_decoder
    import morse_pkg::*;
#(
    parameter int DOT_MAX = 2,
    parameter int LGAP    = 3,
    parameter int CNT_W   = 4
) (
    input  logic              Clock,
    input  logic              Reset,
    morse_decoder_if.slave    bus
);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   count_q, count_d, count_inc;
    logic [3:0]         pattern_q, pattern_d;
    logic [2:0]         len_q, len_d;
    logic               ovf_q, ovf_d;
    logic [4:0]         letter_q, letter_d;
    logic               letter_valid_q, letter_valid_d;
    logic               error_q, error_d;
    logic               busy_q, busy_d;
    logic               lut_hit;
    logic [4:0]         lut_code;
    logic               sym;

    morse_lut u_lut (
        .pattern (pattern_q),
        .len     (len_q),
        .hit     (lut_hit),
        .code    (lut_code)
    );

    // A tick arriving with the key edge is credited before the transition.
    assign count_inc = (bus.tick && count_q != '1) ? count_q + 1'b1 : count_q;
    assign sym       = (count_inc > CNT_W'(DOT_MAX)) ? SYM_DASH : SYM_DOT;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q        <= S_IDLE;
            count_q        <= '0;
            pattern_q      <= '0;
            len_q          <= '0;
            ovf_q          <= 1'b0;
            letter_q       <= '0;
            letter_valid_q <= 1'b0;
            error_q        <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            count_q        <= count_d;
            pattern_q      <= pattern_d;
            len_q          <= len_d;
            ovf_q          <= ovf_d;
            letter_q       <= letter_d;
            letter_valid_q <= letter_valid_d;
            error_q        <= error_d;
            busy_q         <= busy_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        pattern_d = pattern_q;
        len_d     = len_q;
        ovf_d     = ovf_q;
        case (state_q)
            S_IDLE: begin
                if (bus.key) begin
                    state_d = S_PRESS;
                    count_d = '0;
                end
            end
            S_PRESS: begin
                count_d = count_inc;
                if (!bus.key) begin
                    count_d = '0;
                    if (count_inc == '0) begin
                        // Sub-tick glitch: drop it, resume wherever we were.
                        state_d = (len_q == 3'd0) ? S_IDLE : S_GAP;
                    end else begin
                        pattern_d = {pattern_q[2:0], sym};
                        if (len_q < MAX_SYM)
                            len_d = len_q + 3'd1;
                        else
                            ovf_d = 1'b1;
                        state_d = S_GAP;
                    end
                end
            end
            S_GAP: begin
                count_d = count_inc;
                if (bus.key) begin
                    state_d = S_PRESS;
                    count_d = '0;
                end else if (bus.tick && count_inc == CNT_W'(LGAP)) begin
                    state_d = S_EMIT;
                end
            end
            S_EMIT: begin
                state_d   = S_IDLE;
                count_d   = '0;
                pattern_d = '0;
                len_d     = '0;
                ovf_d     = 1'b0;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Result is registered on the GAP->EMIT edge so the pulse lines up with EMIT.
    always_comb begin
        letter_d       = letter_q;
        letter_valid_d = 1'b0;
        error_d        = 1'b0;
        busy_d         = (state_d != S_IDLE);
        if (state_q == S_GAP && state_d == S_EMIT) begin
            if (!ovf_q && lut_hit) begin
                letter_valid_d = 1'b1;
                letter_d       = lut_code;
            end else begin
                error_d = 1'b1;
            end
        end
    end

    assign bus.letter       = letter_q;
    assign bus.letter_valid = letter_valid_q;
    assign bus.error        = error_q;
    assign bus.busy         = busy_q;

endmodule

// File: tb/tb_morse_decoder.sv
// Directed bench for morse_decoder: table of characters (press lengths in ticks)
// with expected letter/error results, plus glitch and mid-character reset sequences.
module tb_morse_decoder;

    logic Clock = 1'b0;
    logic Reset = 1'b1;
    int   total = 0;
    int   bad   = 0;
    int   vcnt  = 0;
    int   ecnt  = 0;
    int   cyc   = 0;

    morse_decoder_if ifc ();

    morse_decoder #(.DOT_MAX(2), .LGAP(3), .CNT_W(4)) dut (
        .Clock (Clock),
        .Reset (Reset),
        .bus   (ifc)
    );

    initial forever #5 Clock = ~Clock;

    // One-cycle tick every 4 clocks.
    initial begin
        ifc.tick = 1'b0;
        forever begin
            @(negedge Clock);
            cyc = cyc + 1;
            ifc.tick = (cyc % 4 == 0);
        end
    end

    always @(negedge Clock) begin
        if (ifc.letter_valid) vcnt <= vcnt + 1;
        if (ifc.error)        ecnt <= ecnt + 1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required finish earlier");
        $fatal(1, "timeout");
    end

    typedef struct {
        int         nsym;
        int         press [5];
        logic       exp_valid;
        logic       exp_err;
        logic [4:0] exp_letter;
    } vec_t;

    vec_t vec [12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total = total + 1;
        if (act !== exp) begin
            bad = bad + 1;
            $display("FAIL %s: got %0d required %0d", name, act, exp);
        end
    endtask

    task automatic set_vec(input int idx, input int n, input int a, input int b, input int c,
                           input int d, input int e, input logic v, input logic er,
                           input logic [4:0] l);
        vec[idx].nsym      = n;
        vec[idx].press[0]  = a;
        vec[idx].press[1]  = b;
        vec[idx].press[2]  = c;
        vec[idx].press[3]  = d;
        vec[idx].press[4]  = e;
        vec[idx].exp_valid = v;
        vec[idx].exp_err   = er;
        vec[idx].exp_letter = l;
    endtask

    // Returns at the negedge following the n-th tick edge.
    task automatic wait_ticks(input int n);
        int c = 0;
        while (c < n) begin
            @(posedge Clock);
            if (ifc.tick) c = c + 1;
        end
        @(negedge Clock);
    endtask

    task automatic press(input int n);
        ifc.key = 1'b1;
        if (n == 0) @(negedge Clock);
        else        wait_ticks(n);
        ifc.key = 1'b0;
    endtask

    task automatic run_char(input int idx, input string name);
        int v0, e0;
        wait_ticks(1);
        v0 = vcnt;
        e0 = ecnt;
        for (int i = 0; i < vec[idx].nsym; i++) begin
            press(vec[idx].press[i]);
            if (i < vec[idx].nsym - 1) wait_ticks(1);
        end
        chk({name, " busy_during"}, 32'(ifc.busy), 32'd1);
        wait_ticks(3);
        chk({name, " letter_valid"}, 32'(ifc.letter_valid), 32'(vec[idx].exp_valid));
        chk({name, " error"}, 32'(ifc.error), 32'(vec[idx].exp_err));
        chk({name, " letter"}, 32'(ifc.letter), 32'(vec[idx].exp_letter));
        $display("char %s: letter=%0d valid=%0b err=%0b", name, ifc.letter,
                 ifc.letter_valid, ifc.error);
        @(negedge Clock);
        chk({name, " valid_one_cycle"}, 32'(ifc.letter_valid), 32'd0);
        chk({name, " error_one_cycle"}, 32'(ifc.error), 32'd0);
        chk({name, " busy_after"}, 32'(ifc.busy), 32'd0);
        @(posedge Clock);
        chk({name, " valid_pulses"}, 32'(vcnt - v0), 32'(vec[idx].exp_valid));
        chk({name, " error_pulses"}, 32'(ecnt - e0), 32'(vec[idx].exp_err));
    endtask

    initial begin
        int v0, e0;
        //          idx n  presses (ticks)    valid err  letter
        set_vec(0,  1, 1, 0, 0, 0, 0, 1'b1, 1'b0, 5'd4);   // E
        set_vec(1,  1, 3, 0, 0, 0, 0, 1'b1, 1'b0, 5'd19);  // T
        set_vec(2,  1, 2, 0, 0, 0, 0, 1'b1, 1'b0, 5'd4);   // 2 ticks still a dot
        set_vec(3,  4, 1, 3, 1, 1, 0, 1'b1, 1'b0, 5'd11);  // L .-..
        set_vec(4,  5, 1, 1, 1, 1, 1, 1'b0, 1'b1, 5'd11);  // 5 dots: overflow
        set_vec(5,  4, 3, 3, 3, 3, 0, 1'b0, 1'b1, 5'd11);  // ---- not a letter
        set_vec(6,  2, 1, 3, 0, 0, 0, 1'b1, 1'b0, 5'd0);   // A .-
        set_vec(7,  4, 3, 3, 1, 3, 0, 1'b1, 1'b0, 5'd16);  // Q --.-
        set_vec(8,  3, 1, 1, 1, 0, 0, 1'b1, 1'b0, 5'd18);  // S ...
        set_vec(9,  4, 1, 1, 3, 3, 0, 1'b0, 1'b1, 5'd18);  // ..-- not a letter
        set_vec(10, 1, 17, 0, 0, 0, 0, 1'b1, 1'b0, 5'd19); // long press saturates: T
        set_vec(11, 4, 3, 3, 1, 1, 0, 1'b1, 1'b0, 5'd25);  // Z --..

        ifc.key = 1'b0;
        Reset   = 1'b1;
        repeat (3) @(negedge Clock);
        Reset = 1'b0;
        chk("reset letter", 32'(ifc.letter), 32'd0);
        chk("reset letter_valid", 32'(ifc.letter_valid), 32'd0);
        chk("reset error", 32'(ifc.error), 32'd0);
        chk("reset busy", 32'(ifc.busy), 32'd0);

        for (int i = 0; i < 12; i++) run_char(i, $sformatf("vec%0d", i));

        // Key pulse shorter than one tick period: no character starts.
        wait_ticks(1);
        v0 = vcnt;
        e0 = ecnt;
        press(0);
        @(negedge Clock);
        chk("glitch busy_soon", 32'(ifc.busy), 32'd0);
        wait_ticks(5);
        chk("glitch busy", 32'(ifc.busy), 32'd0);
        chk("glitch valid_pulses", 32'(vcnt - v0), 32'd0);
        chk("glitch error_pulses", 32'(ecnt - e0), 32'd0);
        chk("glitch letter_held", 32'(ifc.letter), 32'd25);
        $display("glitch: busy=%0b letter=%0d", ifc.busy, ifc.letter);

        // Reset during the third press discards the character.
        wait_ticks(1);
        v0 = vcnt;
        e0 = ecnt;
        press(1);
        wait_ticks(1);
        press(3);
        wait_ticks(1);
        ifc.key = 1'b1;
        wait_ticks(1);
        chk("midreset busy_before", 32'(ifc.busy), 32'd1);
        Reset   = 1'b1;
        ifc.key = 1'b0;
        @(negedge Clock);
        Reset = 1'b0;
        chk("midreset letter", 32'(ifc.letter), 32'd0);
        chk("midreset letter_valid", 32'(ifc.letter_valid), 32'd0);
        chk("midreset error", 32'(ifc.error), 32'd0);
        chk("midreset busy", 32'(ifc.busy), 32'd0);
        wait_ticks(4);
        chk("midreset valid_pulses", 32'(vcnt - v0), 32'd0);
        chk("midreset error_pulses", 32'(ecnt - e0), 32'd0);
        $display("midreset: letter=%0d busy=%0b", ifc.letter, ifc.busy);
        run_char(0, "after_reset_E");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
